// File: rtl/memarb_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
package memarb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
   typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_4B, SZ_8B} size_e;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Byte-wide memory port shared by instruction fetch and split data accesses.
// Define MEMARB_FAIR_EN to forbid back-to-back data transfers out of DONE.
module mem_port_arbiter
   import memarb_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int MAX_BYTES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [7:0]        if_data,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_busy,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [7:0]        m_wdata,
   output logic              m_we,
   input  logic [7:0]        m_read
);

   localparam int CNT_W = $clog2(MAX_BYTES);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                we_q;
   size_e               size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;

   logic                can_acc;
   logic                last_byte;
   logic                xfer;

`ifdef MEMARB_FAIR_EN
   assign can_acc = (state_q == IDLE);
`else
   assign can_acc = (state_q == IDLE) || (state_q == DONE);
`endif

   assign xfer      = (state_q == XFER);
   assign last_byte = (4'(cnt_q) == size_bytes(size_q) - 4'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_1B;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            XFER: begin
               if (!we_q) rdata_q[BYTE_W*cnt_q +: BYTE_W] <= m_read;
               cnt_q <= cnt_q + 1'b1;
               if (last_byte) state_q <= DONE;
            end
            default: begin
               if (can_acc && d_req) begin
                  we_q    <= d_we;
                  size_q  <= size_e'(d_size);
                  addr_q  <= d_addr;
                  wdata_q <= d_wdata;
                  cnt_q   <= '0;
                  if (!d_we) rdata_q <= '0;
                  state_q <= XFER;
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   // Fetch is served in every cycle that is not moving a data byte.
   assign if_valid = !xfer;
   assign if_data  = m_read;
   assign d_busy   = (state_q != IDLE);
   assign d_done   = (state_q == DONE);
   assign d_rdata  = rdata_q;
   assign m_addr   = xfer ? addr_q + ADDR_W'(cnt_q) : if_addr;
   assign m_we     = xfer && we_q;
   assign m_wdata  = wdata_q[BYTE_W*cnt_q +: BYTE_W];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide memory port between the instruction fetcher (port 0) and the data load/store path (port 1).
- Data accesses of 1/2/4/8 bytes are split into byte transfers, one byte per cycle, and assembled into a 64-bit word (little-endian).
- Fetch owns the port whenever no data transfer is in flight.
- Memory read is combinational: m_read corresponds to m_addr in the same cycle. Memory write is synchronous: it happens at posedge when m_we=1.

Parameters:
ADDR_W, 64, width of all byte addresses
DATA_W, 64, width of the data word; must equal 8*MAX_BYTES
MAX_BYTES, 8, largest data access size in bytes

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous, active-low reset
if_addr  in  ADDR_W  fetcher byte address
if_data  out  8  byte returned to fetcher; equals m_read
if_valid  out  1  fetcher owns the port this cycle; if_data is meaningful
d_req  in  1  data request; sampled only when the arbiter can accept
d_we  in  1  1=store, 0=load
d_size  in  2  0=1B, 1=2B, 2=4B, 3=8B
d_addr  in  ADDR_W  data start byte address
d_wdata  in  DATA_W  store data, little-endian; only the low bytes are used
d_busy  out  1  request accepted and not yet completed
d_done  out  1  one-cycle completion pulse
d_rdata  out  DATA_W  load result, zero-extended; held until the next accept
m_addr  out  ADDR_W  memory byte address
m_wdata  out  8  memory write byte
m_we  out  1  memory write enable
m_read  in  8  memory read byte

Behaviour:
- States: IDLE, XFER, DONE.
- Reset (rst=0, async): state=IDLE, byte counter=0, latched request=0, d_rdata=0.
- Outputs while in reset: d_busy=0, d_done=0, m_we=0, if_valid=1, m_addr=if_addr.
- IDLE and DONE:
  - m_addr=if_addr, m_we=0, if_valid=1.
- Accept:
  - Occurs at a posedge in IDLE with d_req=1.
  - Latches d_we, d_size, d_addr, d_wdata; sets cnt=0; state moves to XFER.
  - If the access is a load, d_rdata is cleared to 0 at accept.
  - The fetch cycle during the accept edge is still served normally.
- XFER:
  - if_valid=0.
  - m_addr = addr_q + cnt, modulo 2^ADDR_W (wraps from all-ones to 0).
  - Load: at each posedge, d_rdata[8*cnt +: 8] <= m_read.
  - Store: m_we=1, m_wdata = wdata_q[8*cnt +: 8].
  - cnt increments every cycle. When cnt = nbytes-1, the next state is DONE.
  - Total XFER length = nbytes cycles (1, 2, 4 or 8).
- DONE:
  - Lasts exactly one cycle, with d_done=1 and d_rdata final. Fetch is served.
  - Next state is IDLE, unless the back-to-back rule applies (see Optional Feature).
- d_busy=1 in XFER and DONE.
- d_req is ignored while in XFER.
- Request-to-done latency: the accept edge, plus nbytes XFER cycles, then DONE. For a 4-byte access, d_done is high in the 5th cycle after the accept edge.
- Misaligned addresses are legal; no alignment check is performed.
- Reset asserted mid-XFER:
  - The transfer is abandoned; no further bytes are written; d_done is never pulsed.
  - Partial store bytes already written stay in memory.
- d_addr/d_wdata changing after accept has no effect.

Optional Feature:
- Macro: MEMARB_FAIR_EN.
- Without the macro:
  - DONE with d_req=1 accepts the new request directly (latch and go to XFER), giving back-to-back transfers with one fetch cycle between them.
- With the macro defined:
  - DONE always goes to IDLE and ignores d_req.
  - A new request can only be accepted from IDLE, so at least 2 fetch cycles separate consecutive data transfers.

Decomposition:
- Package memarb_pkg holds:
  - the state enum (IDLE/XFER/DONE);
  - the size enum (SZ_1B..SZ_8B);
  - function size_bytes(size) returning a 4-bit byte count;
  - constant BYTE_W=8.
- No sub-module; a single flat module.

Test Plan:
- Idle fetch: no d_req, if_addr=0x100 → m_addr=0x100, if_valid=1, if_data=m_read each cycle, m_we=0.
- 4B load at 0x20, memory bytes 11,22,33,44 → XFER lasts 4 cycles with m_addr 0x20..0x23 and if_valid=0; DONE pulse; d_rdata=0x44332211.
- 2B store at 0xFFFF_FFFF_FFFF_FFFF, wdata=0xBEEF → writes EF to the all-ones address and BE to 0x0; d_done pulses once.
- d_req held high over two 1B loads → without MEMARB_FAIR_EN there is 1 fetch cycle between XFERs; with the macro there are 2.
- rst dropped at 3rd byte of an 8B store → m_we=0 immediately, state=IDLE, d_busy=0, no d_done, if_valid=1.
- 8B load → zero-extend not needed; 1B load of 0x80 → d_rdata=0x0000_0000_0000_0080.
